euler_packet_tx: RTL and testbench

Downstream framing stage for the BNO055 attitude path. It takes completed roll/pitch samples from the I2C Euler reader, rate-limits them, and serialises each sample into an 8-byte framed, checksummed packet. Bytes go out one at a time over a byte handshake to `uart_tx`. It replaces ad-hoc packet sequencing in the top level and adds sequence numbering, integrity checking and overrun accounting for the host attitude display.

---
 rtl/euler_packet_tx.sv | 182 ++++++++++++++++++
 tb/tb_euler_packet_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/euler_packet_tx.sv
// Frames roll/pitch samples into 8-byte checksummed packets and hands them to
// a UART one byte at a time. Packet starts are rate-limited by an idle-gap counter.
module euler_packet_tx #(
  parameter int         GAP_CLKS   = 2500000,
  parameter logic [7:0] START_BYTE = 8'hAA,
  parameter logic [7:0] END_BYTE   = 8'h55
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sample_valid,
  input  logic [15:0] i_roll,
  input  logic [15:0] i_pitch,
  output logic        o_tx_dv,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic [7:0]  o_seq,
  output logic [7:0]  o_drop_count
);

  localparam int GAP_W = (GAP_CLKS < 2) ? 1 : $clog2(GAP_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CLKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t state_reg, state_next;
  logic [2:0]       idx_reg, idx_next;
  logic             tx_dv_reg, tx_dv_next;
  logic [7:0]       tx_byte_reg, tx_byte_next;
  logic             busy_reg, busy_next;

  logic [15:0]      hold_roll_reg, hold_pitch_reg;
  logic             pending_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [7:0]       seq_reg;
  logic [7:0]       drop_reg;
  logic [7:0]       pkt_seq_reg;
  logic [15:0]      pkt_roll_reg, pkt_pitch_reg;

  logic gap_ok;
  logic start;
  logic pkt_done;

  assign gap_ok   = (gap_reg == GAP_MAX);
  assign start    = (state_reg == ST_IDLE) && pending_reg && gap_ok;
  assign pkt_done = (state_reg == ST_WAIT) && i_tx_done && (idx_reg == 3'd7);

  // Payload bytes in wire order; the checksum is a running XOR over them.
  logic [7:0] payload     [5];
  logic [7:0] chk_chain   [6];
  logic [7:0] frame_bytes [8];

  assign payload[0] = pkt_seq_reg;
  assign payload[1] = pkt_roll_reg[7:0];
  assign payload[2] = pkt_roll_reg[15:8];
  assign payload[3] = pkt_pitch_reg[7:0];
  assign payload[4] = pkt_pitch_reg[15:8];

  assign chk_chain[0] = 8'h00;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_payload
      assign chk_chain[gi+1]   = chk_chain[gi] ^ payload[gi];
      assign frame_bytes[gi+1] = payload[gi];
    end
  endgenerate

  assign frame_bytes[0] = START_BYTE;
  assign frame_bytes[6] = chk_chain[5];
  assign frame_bytes[7] = END_BYTE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= 3'd0;
      tx_dv_reg   <= 1'b0;
      tx_byte_reg <= 8'h00;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      tx_dv_reg   <= tx_dv_next;
      tx_byte_reg <= tx_byte_next;
      busy_reg    <= busy_next;
    end
  end

  // Outputs are registered from next-state values. Byte 0 is strobed straight
  // out of IDLE so it appears the cycle after the start condition; SEND then
  // issues each later byte one cycle after the WAIT->SEND step.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    tx_dv_next   = 1'b0;
    tx_byte_next = tx_byte_reg;
    busy_next    = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_WAIT;
          idx_next     = 3'd0;
          tx_dv_next   = 1'b1;
          tx_byte_next = START_BYTE;
          busy_next    = 1'b1;
        end
      end
      ST_SEND: begin
        tx_dv_next   = 1'b1;
        tx_byte_next = frame_bytes[idx_reg];
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (idx_reg == 3'd7) begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = ST_SEND;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sample holding, overrun accounting, gap timing and packet snapshot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_roll_reg  <= 16'h0000;
      hold_pitch_reg <= 16'h0000;
      pending_reg    <= 1'b0;
      gap_reg        <= '0;
      seq_reg        <= 8'h00;
      drop_reg       <= 8'h00;
      pkt_seq_reg    <= 8'h00;
      pkt_roll_reg   <= 16'h0000;
      pkt_pitch_reg  <= 16'h0000;
    end else begin
      if (i_sample_valid) begin
        hold_roll_reg  <= i_roll;
        hold_pitch_reg <= i_pitch;
        pending_reg    <= 1'b1;
      end else if (start) begin
        pending_reg <= 1'b0;
      end

      // A sample landing on the start cycle replaces nothing in flight, so it is not a drop.
      if (i_sample_valid && pending_reg && !start && (drop_reg != 8'hFF)) begin
        drop_reg <= drop_reg + 8'd1;
      end

      if (pkt_done) begin
        gap_reg <= '0;
      end else if (!gap_ok) begin
        gap_reg <= gap_reg + 1'b1;
      end

      if (pkt_done) begin
        seq_reg <= seq_reg + 8'd1;
      end

      if (start) begin
        pkt_seq_reg   <= seq_reg;
        pkt_roll_reg  <= hold_roll_reg;
        pkt_pitch_reg <= hold_pitch_reg;
      end
    end
  end

  assign o_tx_dv      = tx_dv_reg;
  assign o_tx_byte    = tx_byte_reg;
  assign o_busy       = busy_reg;
  assign o_seq        = seq_reg;
  assign o_drop_count = drop_reg;

endmodule

// File: tb/tb_euler_packet_tx.sv
// Directed bench for euler_packet_tx: expected packet bytes are queued when a
// sample is driven and compared as the DUT strobes bytes out.
module tb_euler_packet_tx;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] roll, pitch;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        busy;
  logic [7:0]  seq;
  logic [7:0]  drop;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int resp_lat = 1;
  int stab_err = 0;

  logic [7:0] got_q [$];
  int         gcyc_q[$];
  logic [7:0] exp_q [$];
  logic [7:0] last_byte = 8'h00;
  logic       prev_dv = 1'b0;

  euler_packet_tx #(.GAP_CLKS(GAP), .START_BYTE(8'hAA), .END_BYTE(8'h55)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_sample_valid(sample_valid),
    .i_roll(roll),
    .i_pitch(pitch),
    .o_tx_dv(tx_dv),
    .o_tx_byte(tx_byte),
    .i_tx_done(tx_done),
    .o_busy(busy),
    .o_seq(seq),
    .o_drop_count(drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte monitor: captures strobes, flags multi-cycle strobes and byte changes mid-packet.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_dv) begin
        got_q.push_back(tx_byte);
        gcyc_q.push_back(cyc);
        last_byte = tx_byte;
      end else if (busy && (tx_byte !== last_byte)) begin
        stab_err++;
      end
      if (tx_dv && prev_dv) stab_err++;
      prev_dv = tx_dv;
    end
  end

  // UART model: acknowledges each byte resp_lat cycles after its strobe.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_dv) begin
        repeat (resp_lat) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] r, input logic [15:0] p);
    roll = r;
    pitch = p;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic push_pkt(input logic [7:0] s, input logic [15:0] r, input logic [15:0] p);
    logic [7:0] c;
    c = s ^ r[7:0] ^ r[15:8] ^ p[7:0] ^ p[15:8];
    exp_q.push_back(8'hAA);
    exp_q.push_back(s);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(p[7:0]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(c);
    exp_q.push_back(8'h55);
  endtask

  task automatic wait_bytes(input int n, input bit need_idle, input string tag);
    int t;
    t = 0;
    while (!(got_q.size() >= n && (!need_idle || !busy)) && t < 3000) begin
      tick();
      t++;
    end
    chk({tag, " timeout"}, 32'(t < 3000), 32'd1);
  endtask

  task automatic check_pkt(input string tag, output int start_cyc);
    logic [7:0] obs, e;
    int c;
    start_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      obs = 8'hxx;
      c = -1;
      e = 8'hxx;
      if (got_q.size() > 0) begin
        obs = got_q.pop_front();
        c = gcyc_q.pop_front();
      end
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (i == 0) start_cyc = c;
      chk($sformatf("%s byte%0d", tag, i), {24'h0, obs}, {24'h0, e});
    end
  endtask

  initial begin
    int s, s_prev, t, busy_lo, quiet, c0;
    logic [7:0] b;
    logic [15:0] r, p;

    sample_valid = 1'b0;
    roll = 16'h0;
    pitch = 16'h0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset tx_dv", 32'(tx_dv), 32'd0);
    chk("reset tx_byte", 32'(tx_byte), 32'h00);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset seq", 32'(seq), 32'h00);
    chk("reset drop", 32'(drop), 32'h00);
    rst = 1'b0;

    // Basic frame
    strobe(16'h0168, 16'hFFF0);
    push_pkt(8'h00, 16'h0168, 16'hFFF0);
    wait_bytes(8, 1'b1, "basic");
    check_pkt("basic", s);
    chk("basic seq after", 32'(seq), 32'h01);

    // Slow handshake: 500 cycles per byte
    resp_lat = 500;
    strobe(16'h1234, 16'h5678);
    push_pkt(8'h01, 16'h1234, 16'h5678);
    t = 0;
    busy_lo = 0;
    while (!(got_q.size() >= 8 && !busy) && t < 20000) begin
      tick();
      t++;
      if (got_q.size() >= 1 && got_q.size() < 8 && !busy) busy_lo++;
    end
    chk("hs timeout", 32'(t < 20000), 32'd1);
    chk("hs busy low cycles", 32'(busy_lo), 32'd0);
    chk("hs strobe count", 32'(got_q.size()), 32'd8);
    chk("hs stability", 32'(stab_err), 32'd0);
    check_pkt("hs", s);
    resp_lat = 1;

    // Overrun: three samples before the gap expires, latest wins
    strobe(16'h0010, 16'h0000);
    strobe(16'h0020, 16'h0000);
    strobe(16'h0030, 16'h0000);
    push_pkt(8'h02, 16'h0030, 16'h0000);
    wait_bytes(8, 1'b1, "overrun");
    check_pkt("overrun", s);
    chk("overrun drop", 32'(drop), 32'd2);

    // Collision: 0x1111 in flight, 0x2222 on the start cycle of the next packet
    strobe(16'hAAAA, 16'h0000);
    push_pkt(8'h03, 16'hAAAA, 16'h0000);
    wait_bytes(1, 1'b0, "col dv");
    strobe(16'h1111, 16'h0000);
    push_pkt(8'h04, 16'h1111, 16'h0000);
    wait_bytes(8, 1'b1, "col pkt0");
    check_pkt("col0", s);
    repeat (4) tick();
    strobe(16'h2222, 16'h0000);
    chk("col start dv", 32'(tx_dv), 32'd1);
    chk("col start byte", 32'(tx_byte), 32'hAA);
    push_pkt(8'h05, 16'h2222, 16'h0000);
    wait_bytes(16, 1'b1, "col pkts");
    check_pkt("col1", s);
    check_pkt("col2", s);
    chk("col drop", 32'(drop), 32'd2);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) strobe(16'(i), 16'(i));
    t = 0;
    quiet = 0;
    while (quiet < 60 && t < 20000) begin
      tick();
      t++;
      if (busy) quiet = 0;
      else quiet++;
    end
    chk("sat drain timeout", 32'(t < 20000), 32'd1);
    chk("sat drop", 32'(drop), 32'hFF);
    got_q.delete();
    gcyc_q.delete();

    // Reset after the fourth strobe of a packet
    strobe(16'hBEEF, 16'hCAFE);
    wait_bytes(4, 1'b0, "rst dv4");
    rst = 1'b1;
    tick();
    chk("rst tx_dv", 32'(tx_dv), 32'd0);
    chk("rst tx_byte", 32'(tx_byte), 32'h00);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst seq", 32'(seq), 32'h00);
    chk("rst drop", 32'(drop), 32'h00);
    c0 = cyc;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      if (gcyc_q.size() > 0) void'(gcyc_q.pop_front());
      if (i == 0) chk("rst old byte0", 32'(b), 32'hAA);
      if (i == 2) chk("rst old byte2", 32'(b), 32'hEF);
      if (i == 3) chk("rst old byte3", 32'(b), 32'hBE);
    end
    strobe(16'h4321, 16'h8765);
    push_pkt(8'h00, 16'h4321, 16'h8765);
    wait_bytes(8, 1'b1, "rst pkt");
    check_pkt("rst pkt", s);
    chk("rst gap to first strobe", 32'(s - c0), 32'(GAP + 1));

    // Sequence wrap with back-to-back pending samples
    strobe(16'h5A00, 16'hFFFF);
    push_pkt(8'h01, 16'h5A00, 16'hFFFF);
    for (int k = 0; k < 257; k++) begin
      wait_bytes(8 * k + 1, 1'b0, "wrap dv");
      if (k < 256) begin
        r = {8'(k + 1) ^ 8'h5A, 8'(k + 1)};
        p = 16'hFFFF - 16'(k + 1);
        strobe(r, p);
        push_pkt(8'(k + 2), r, p);
      end
    end
    wait_bytes(8 * 257, 1'b1, "wrap end");
    s_prev = 0;
    for (int k = 0; k < 257; k++) begin
      check_pkt($sformatf("wrap%0d", k), s);
      if (k > 0) chk($sformatf("wrap spacing%0d", k), 32'(s - s_prev), 32'd28);
      s_prev = s;
    end
    chk("wrap seq after", 32'(seq), 32'h02);
    chk("final stability", 32'(stab_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
